// File: rtl/disp_bcd_seg.sv
// Binary to seven-segment display driver.
// Decimal via serial double dabble, hex via direct nibble mapping.
module disp_bcd_seg #(
  parameter int WIDTH          = 16,
  parameter int DIGITS         = 6,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (WIDTH > BW) ? WIDTH : BW;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [6:0] BLANK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  sh;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic [CW-1:0]     cnt;
  logic              hex_q;
  logic              blank_q;
  logic              ovf;
  logic [PW-1:0]     val_pad;
  logic [PW-1:0]     sh_pad;
  logic [BW-1:0]     digits;
  logic [7*DIGITS-1:0] seg_nx;
  logic              seen;
  logic [3:0]        nib;
  logic [6:0]        code;

  function automatic logic [6:0] enc(input logic [3:0] d);
    unique case (d)
      4'h0: enc = 7'h3F;
      4'h1: enc = 7'h06;
      4'h2: enc = 7'h5B;
      4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;
      4'h5: enc = 7'h6D;
      4'h6: enc = 7'h7D;
      4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h6F;
      4'hA: enc = 7'h77;
      4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;
      4'hD: enc = 7'h5E;
      4'hE: enc = 7'h79;
      4'hF: enc = 7'h71;
    endcase
  endfunction

  assign val_pad  = PW'(value);
  assign sh_pad   = PW'(sh);
  assign busy     = (state != IDLE);
  assign overflow = ovf;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load) state_nx = hex_mode ? DONE : CONV;
      CONV: if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the top digit so leading zeros blank until the first nonzero.
  always_comb begin
    digits = hex_q ? sh_pad[BW-1:0] : bcd;
    seen   = 1'b0;
    nib    = 4'd0;
    code   = 7'h00;
    seg_nx = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = digits[4*i +: 4];
      if (nib != 4'd0 || i == 0) seen = 1'b1;
      if (ovf) code = 7'h40;
      else if (blank_q && !seen) code = 7'h00;
      else code = enc(nib);
      seg_nx[7*i +: 7] = (SEG_ACTIVE_LOW != 0) ? ~code : code;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      hex_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      seg     <= {DIGITS{BLANK}};
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            sh      <= value;
            bcd     <= '0;
            cnt     <= '0;
            hex_q   <= hex_mode;
            blank_q <= blank_lz;
            ovf     <= hex_mode && ((val_pad >> BW) != '0);
          end
        end
        CONV: begin
          if (bcd_adj[BW-1]) ovf <= 1'b1;
          bcd <= {bcd_adj[BW-2:0], sh[WIDTH-1]};
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          seg  <= seg_nx;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
